// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with request-to-send, ACK check and watchdog.
// Lines are driven only through active-high pull-low enables; the top level makes them open-collector.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       clk_ps2,
    input  logic       ps2_data_in,
    output logic       clk_ps2_low,
    output logic       ps2_data_low,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       done,
    output logic       err
);
    localparam int CMAX = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_prev_q;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dlow_q, dlow_d;
    logic          ack_ok_q, ack_ok_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fe;

    assign fe = clk_prev_q & ~clk_sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            frame_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            dlow_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= {clk_sync_q[0], clk_ps2};
            dat_sync_q <= {dat_sync_q[0], ps2_data_in};
            clk_prev_q <= clk_sync_q[1];
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            dlow_q     <= dlow_d;
            ack_ok_q   <= ack_ok_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dlow_d   = dlow_q;
        ack_ok_d = ack_ok_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: if (tx_start) begin
                frame_d = {1'b1, ~^tx_data, tx_data};
                cnt_d   = '0;
                state_d = INHIBIT;
            end
            INHIBIT: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(INHIBIT_CYCLES - 1) ? RTS : INHIBIT;
            end
            // The RTS cycle itself is the first watchdog cycle.
            RTS: begin
                dlow_d  = 1'b1;
                idx_d   = '0;
                cnt_d   = CW'(1);
                state_d = SHIFT;
            end
            default: begin
                cnt_d = fe ? '0 : cnt_q + 1'b1;
                if (state_q == SHIFT && fe) begin
                    dlow_d  = ~frame_q[idx_q];
                    idx_d   = idx_q + 1'b1;
                    state_d = idx_q == 4'd9 ? ACK : SHIFT;
                end
                if (state_q == ACK && fe) begin
                    ack_ok_d = ~dat_sync_q[1];
                    err_d    = dat_sync_q[1];
                    state_d  = WAIT_IDLE;
                end
                if (state_q == WAIT_IDLE && clk_sync_q[1] && dat_sync_q[1]) begin
                    done_d  = ack_ok_q;
                    state_d = IDLE;
                end
                // A failed ACK has already reported its error, so a later timeout stays silent.
                if (!fe && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    done_d  = 1'b0;
                    err_d   = !(state_q == WAIT_IDLE && !ack_ok_q);
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        clk_ps2_low  = state_q == INHIBIT;
        ps2_data_low = state_q == RTS || (state_q == SHIFT && dlow_q);
        busy         = state_q != IDLE;
        rx_inhibit   = state_q != IDLE;
        done         = done_q;
        err          = err_q;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model and a bit scoreboard for ps2_host_tx.
module tb_ps2_host_tx;
    logic       clk = 1'b0;
    logic       reset, tx_start;
    logic [7:0] tx_data;
    logic       dev_clk, dev_data;
    logic       clk_ps2_low, ps2_data_low, busy, rx_inhibit, done, err;
    logic       clk_pin, data_pin;
    int         n_cmp = 0, n_bad = 0;
    int         done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int         d0, e0, len;
    logic       exp_q[$];

    assign clk_pin  = dev_clk & ~clk_ps2_low;
    assign data_pin = dev_data & ~ps2_data_low;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
        .clk_ps2(clk_pin), .ps2_data_in(data_pin),
        .clk_ps2_low(clk_ps2_low), .ps2_data_low(ps2_data_low),
        .busy(busy), .rx_inhibit(rx_inhibit), .done(done), .err(err)
    );

    always @(negedge clk) begin
        done_cnt += int'(done);
        err_cnt  += int'(err);
        both_cnt += int'(done & err);
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = b;
        tx_start = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(~^b);
        exp_q.push_back(1'b1);
        @(negedge clk);
        tx_start = 1'b0;
        chk1("accept_busy", busy, 1'b1);
        chk1("accept_clk_low", clk_ps2_low, 1'b1);
        chk1("accept_rx_inhibit", rx_inhibit, 1'b1);
    endtask

    task automatic wait_rts(output int n);
        n = 1;
        for (int i = 0; i < 200 && clk_ps2_low; i++) begin
            @(negedge clk);
            if (clk_ps2_low) n++;
        end
        chk1("rts_clk_released", clk_ps2_low, 1'b0);
        chk1("rts_data_low", ps2_data_low, 1'b1);
    endtask

    task automatic dev_bits(input int n);
        for (int i = 0; i < n; i++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            chk1($sformatf("busy_bit%0d", i), busy, 1'b1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL sb_empty: observed bit %b expected none", data_pin);
            end else chk1($sformatf("bit%0d", i), data_pin, exp_q.pop_front());
            repeat (20) @(negedge clk);
        end
    endtask

    task automatic dev_ack(input logic ack);
        dev_data = ~ack;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500 && busy; i++) @(negedge clk);
        chk1("return_idle", busy, 1'b0);
        @(negedge clk);
    endtask

    task automatic full_xfer(input logic [7:0] b, input logic ack);
        send(b);
        wait_rts(len);
        repeat (10) @(negedge clk);
        dev_bits(10);
        dev_ack(ack);
        wait_idle();
        chki("sb_drained", exp_q.size(), 0);
        chki("done_pulses", done_cnt - d0, ack ? 1 : 0);
        chki("err_pulses", err_cnt - e0, ack ? 0 : 1);
    endtask

    initial begin
        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = '0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk1("rst_clk_low", clk_ps2_low, 1'b0);
        chk1("rst_data_low", ps2_data_low, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rx_inhibit", rx_inhibit, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);

        full_xfer(8'hED, 1'b1);

        send(8'hF4);
        wait_rts(len);
        chki("inhibit_len", len, 20);
        repeat (10) @(negedge clk);
        dev_bits(10);
        dev_ack(1'b1);
        wait_idle();
        chki("f4_done", done_cnt - d0, 1);
        chki("f4_err", err_cnt - e0, 0);

        full_xfer(8'h00, 1'b0);

        send(8'hED);
        wait_rts(len);
        exp_q.delete();
        len = 0;
        for (int i = 0; i < 3000 && !err; i++) begin
            @(negedge clk);
            len++;
        end
        chki("timeout_cycles", len, 2000);
        chk1("timeout_err", err, 1'b1);
        chk1("timeout_clk_low", clk_ps2_low, 1'b0);
        chk1("timeout_data_low", ps2_data_low, 1'b0);
        chk1("timeout_busy", busy, 1'b0);
        @(negedge clk);
        chki("timeout_err_once", err_cnt - e0, 1);
        chki("timeout_no_done", done_cnt - d0, 0);

        send(8'hF4);
        wait_rts(len);
        repeat (10) @(negedge clk);
        dev_bits(3);
        dev_clk = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk1("midrst_clk_low", clk_ps2_low, 1'b0);
        chk1("midrst_data_low", ps2_data_low, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        repeat (30) @(negedge clk);
        dev_clk = 1'b1;
        repeat (30) @(negedge clk);
        chki("midrst_no_done", done_cnt - d0, 0);
        chki("midrst_no_err", err_cnt - e0, 0);
        exp_q.delete();
        full_xfer(8'hED, 1'b1);

        send(8'hED);
        @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_rts(len);
        repeat (10) @(negedge clk);
        dev_bits(10);
        dev_ack(1'b1);
        wait_idle();
        repeat (100) @(negedge clk);
        chk1("ignored_start_idle", busy, 1'b0);
        chki("ignored_start_done", done_cnt - d0, 1);
        chki("ignored_start_err", err_cnt - e0, 0);
        chki("done_err_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
